// File: rtl/e2prom_pkg.sv
// Shared state encoding and test pattern for the E2PROM write/read-back sequencer.
// No logic: types, constants and a pure function only.
package e2prom_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_WAIT = 3'd2,
    WR_GAP  = 3'd3,
    RD_REQ  = 3'd4,
    RD_WAIT = 3'd5,
    PASS    = 3'd6,
    FAIL    = 3'd7
  } e2prom_state_t;

  localparam logic [7:0] PAT_XOR = 8'hA5;

  // Only the low address byte feeds the pattern, so callers pass addr[7:0].
  function automatic logic [7:0] e2prom_pattern(input logic [7:0] addr_lo);
    return addr_lo ^ PAT_XOR;
  endfunction

endpackage

// File: rtl/e2prom_rw_ctrl.sv
// Purpose: write pattern to BYTE_NUM E2PROM bytes, wait tWR after each, read back and compare.
// Latency: exec one clk after entering a request state; reads back-to-back, writes spaced by WR_WAIT_CYCLES.
// Backpressure: one transaction outstanding; waits indefinitely on i2c_done, which the driver times out.
module e2prom_rw_ctrl
  import e2prom_pkg::*;
#(
  parameter int         BYTE_NUM       = 256,
  parameter int         WR_WAIT_CYCLES = 5000,
  parameter logic       BIT_CTRL       = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        i2c_exec,
  output logic        i2c_rh_wl,
  output logic        bit_ctrl,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_data_w,
  input  logic        i2c_done,
  input  logic        i2c_ack,
  input  logic [7:0]  i2c_data_r,
  output logic        rw_done,
  output logic        rw_result,
  output logic [15:0] err_addr
);

  localparam int          WCW       = (WR_WAIT_CYCLES > 1) ? $clog2(WR_WAIT_CYCLES) : 1;
  localparam int          WLAST     = (WR_WAIT_CYCLES > 0) ? WR_WAIT_CYCLES - 1 : 0;
  localparam logic [16:0] LAST_ADDR = 17'(BYTE_NUM - 1);

  e2prom_state_t  state;
  logic [16:0]    addr_cnt;
  logic [WCW-1:0] wait_cnt;
  logic           gap_last;
  logic           addr_last;
  logic [7:0]     exp_data;

  assign bit_ctrl  = BIT_CTRL;
  // WR_WAIT_CYCLES of 0 and 1 both collapse to a single gap cycle.
  assign gap_last  = (wait_cnt == WCW'(WLAST));
  assign addr_last = (addr_cnt == LAST_ADDR);
  assign exp_data  = e2prom_pattern(addr_cnt[7:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_cnt   <= '0;
      wait_cnt   <= '0;
      i2c_exec   <= 1'b0;
      i2c_rh_wl  <= 1'b0;
      i2c_addr   <= '0;
      i2c_data_w <= '0;
      rw_done    <= 1'b0;
      rw_result  <= 1'b0;
      err_addr   <= '0;
    end else begin
      i2c_exec <= 1'b0;
      case (state)
        IDLE: state <= WR_REQ;

        WR_REQ: begin
          i2c_rh_wl  <= 1'b0;
          i2c_addr   <= addr_cnt[15:0];
          i2c_data_w <= exp_data;
          i2c_exec   <= 1'b1;
          state      <= WR_WAIT;
        end

        WR_WAIT: begin
          if (i2c_done) begin
            if (i2c_ack) begin
              err_addr  <= addr_cnt[15:0];
              rw_done   <= 1'b1;
              rw_result <= 1'b0;
              state     <= FAIL;
            end else begin
              state <= WR_GAP;
            end
          end
        end

        WR_GAP: begin
          if (gap_last) begin
            wait_cnt <= '0;
            if (addr_last) begin
              addr_cnt <= '0;
              state    <= RD_REQ;
            end else begin
              addr_cnt <= addr_cnt + 17'd1;
              state    <= WR_REQ;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RD_REQ: begin
          i2c_rh_wl <= 1'b1;
          i2c_addr  <= addr_cnt[15:0];
          i2c_exec  <= 1'b1;
          state     <= RD_WAIT;
        end

        RD_WAIT: begin
          if (i2c_done) begin
            if (i2c_ack || (i2c_data_r != exp_data)) begin
              err_addr  <= addr_cnt[15:0];
              rw_done   <= 1'b1;
              rw_result <= 1'b0;
              state     <= FAIL;
            end else if (addr_last) begin
              rw_done   <= 1'b1;
              rw_result <= 1'b1;
              state     <= PASS;
            end else begin
              addr_cnt <= addr_cnt + 17'd1;
              state    <= RD_REQ;
            end
          end
        end

        PASS: begin
          rw_done   <= 1'b1;
          rw_result <= 1'b1;
        end

        FAIL: begin
          rw_done   <= 1'b1;
          rw_result <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_e2prom_rw_ctrl.sv
// Directed bench: behavioural I2C driver stand-in with echo memory, fault knobs and protocol checks.
module tb_e2prom_rw_ctrl;

  logic        clk;
  logic        rst_n, rst_n_b;

  logic        i2c_exec, i2c_rh_wl, bit_ctrl, i2c_done, i2c_ack, rw_done, rw_result;
  logic [15:0] i2c_addr, err_addr;
  logic [7:0]  i2c_data_w, i2c_data_r;

  logic        b_exec, b_rh_wl, b_bit_ctrl, b_done, b_ack, b_rw_done, b_rw_result;
  logic [15:0] b_addr, b_err_addr;
  logic [7:0]  b_data_w, b_data_r;

  int n_tests = 0;
  int n_fail  = 0;

  // knobs for the driver stand-in
  int   nack_wr_idx  = -1;
  int   corrupt_addr = -1;
  bit   spur         = 0;

  logic [24:0] log_q[$];   // {rh_wl, addr, data_w} per exec
  logic [7:0]  mem [0:3];
  int          b_wr, b_rd;

  e2prom_rw_ctrl #(.BYTE_NUM(4), .WR_WAIT_CYCLES(10), .BIT_CTRL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .i2c_exec(i2c_exec), .i2c_rh_wl(i2c_rh_wl),
    .bit_ctrl(bit_ctrl), .i2c_addr(i2c_addr), .i2c_data_w(i2c_data_w),
    .i2c_done(i2c_done), .i2c_ack(i2c_ack), .i2c_data_r(i2c_data_r),
    .rw_done(rw_done), .rw_result(rw_result), .err_addr(err_addr)
  );

  e2prom_rw_ctrl #(.BYTE_NUM(1), .WR_WAIT_CYCLES(0), .BIT_CTRL(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .i2c_exec(b_exec), .i2c_rh_wl(b_rh_wl),
    .bit_ctrl(b_bit_ctrl), .i2c_addr(b_addr), .i2c_data_w(b_data_w),
    .i2c_done(b_done), .i2c_ack(b_ack), .i2c_data_r(b_data_r),
    .rw_done(b_rw_done), .rw_result(b_rw_result), .err_addr(b_err_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Driver stand-in for dut: done 3 clks after exec, plus protocol checks.
  initial begin : drv_a
    bit          busy, armed, prev_exec;
    int          cnt, cyc, done_cyc, gap_exp, wr_cnt, spur_cnt;
    logic        cur_rw;
    logic [15:0] cur_addr;
    logic [7:0]  cur_data;
    busy = 0; armed = 0; prev_exec = 0; cnt = 0; cyc = 0; done_cyc = 0;
    gap_exp = 0; wr_cnt = 0; spur_cnt = 0;
    cur_rw = 0; cur_addr = 0; cur_data = 0;
    i2c_done = 0; i2c_ack = 0; i2c_data_r = 0;
    forever begin
      @(negedge clk);
      cyc++;
      i2c_done = 0; i2c_ack = 0; i2c_data_r = 0;
      if (!rst_n) begin
        busy = 0; armed = 0; prev_exec = 0; wr_cnt = 0; spur_cnt = 0;
      end else begin
        if (prev_exec) chk("exec_pulse", i2c_exec, 0);
        if (busy) begin
          cnt--;
          if (cnt == 0) begin
            busy = 0;
            i2c_done = 1;
            chk("hold", {i2c_rh_wl, i2c_addr, i2c_data_w}, {cur_rw, cur_addr, cur_data});
            done_cyc = cyc;
            armed = 1;
            if (!cur_rw) begin
              i2c_ack = (wr_cnt == nack_wr_idx);
              wr_cnt++;
              gap_exp = 12;
              if (spur) spur_cnt = 4;
            end else begin
              gap_exp = 2;
              i2c_data_r = (int'(cur_addr) == corrupt_addr) ? 8'h00 : mem[cur_addr[1:0]];
            end
          end
        end else if (spur_cnt != 0) begin
          spur_cnt--;
          if (spur_cnt == 0) begin
            i2c_done = 1;
            i2c_ack = 1;
          end
        end
        if (i2c_exec && !prev_exec) begin
          chk("idle_at_exec", busy, 0);
          if (armed) chk("gap", cyc - done_cyc, gap_exp);
          armed = 0;
          cur_rw = i2c_rh_wl; cur_addr = i2c_addr; cur_data = i2c_data_w;
          log_q.push_back({i2c_rh_wl, i2c_addr, i2c_data_w});
          if (!i2c_rh_wl) mem[i2c_addr[1:0]] = i2c_data_w;
          busy = 1;
          cnt = 3;
        end
        prev_exec = i2c_exec;
      end
    end
  end

  // Minimal echo driver for dut_b.
  initial begin : drv_b
    bit         bbusy;
    int         bcnt;
    logic [7:0] bmem;
    bbusy = 0; bcnt = 0; bmem = 0; b_wr = 0; b_rd = 0;
    b_done = 0; b_ack = 0; b_data_r = 0;
    forever begin
      @(negedge clk);
      b_done = 0;
      if (!rst_n_b) begin
        bbusy = 0; b_wr = 0; b_rd = 0;
      end else begin
        if (bbusy) begin
          bcnt--;
          if (bcnt == 0) begin
            bbusy = 0;
            b_done = 1;
            b_data_r = bmem;
          end
        end
        if (b_exec) begin
          bbusy = 1;
          bcnt = 2;
          if (b_rh_wl) b_rd++;
          else begin
            b_wr++;
            bmem = b_data_w;
          end
        end
      end
    end
  end

  function automatic int count_reads();
    int n = 0;
    foreach (log_q[i]) if (log_q[i][24]) n++;
    return n;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_exec"}, i2c_exec, 0);
    chk({tag, "_rh_wl"}, i2c_rh_wl, 0);
    chk({tag, "_addr"}, i2c_addr, 0);
    chk({tag, "_data_w"}, i2c_data_w, 0);
    chk({tag, "_done"}, rw_done, 0);
    chk({tag, "_result"}, rw_result, 0);
    chk({tag, "_err"}, err_addr, 0);
  endtask

  task automatic restart();
    rst_n = 0;
    tick();
    tick();
    log_q.delete();
    rst_n = 1;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 1000 && !rw_done; i++) tick();
    chk(tag, rw_done, 1);
    repeat (20) tick();
  endtask

  logic [7:0] exp_wd [4] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};

  task automatic check_full_pass(input string tag);
    chk({tag, "_result"}, rw_result, 1);
    chk({tag, "_err"}, err_addr, 0);
    chk({tag, "_nlog"}, log_q.size(), 8);
    if (log_q.size() == 8) begin
      for (int i = 0; i < 4; i++) begin
        chk({tag, "_wr"}, log_q[i], {1'b0, 16'(i), exp_wd[i]});
        chk({tag, "_rd"}, log_q[i+4][24:8], {1'b1, 16'(i)});
      end
    end
  endtask

  initial begin
    rst_n = 0;
    rst_n_b = 0;
    repeat (3) tick();
    check_reset("rst");
    chk("bit_ctrl_a", bit_ctrl, 1);

    // 1: normal pass
    restart();
    wait_done("t1_done");
    check_full_pass("t1");

    // 2: read mismatch at addr 2
    corrupt_addr = 2;
    restart();
    wait_done("t2_done");
    chk("t2_result", rw_result, 0);
    chk("t2_err", err_addr, 2);
    chk("t2_nlog", log_q.size(), 7);
    chk("t2_nrd", count_reads(), 3);
    corrupt_addr = -1;

    // 3: NACK on second write
    nack_wr_idx = 1;
    restart();
    wait_done("t3_done");
    chk("t3_result", rw_result, 0);
    chk("t3_err", err_addr, 1);
    chk("t3_nlog", log_q.size(), 2);
    chk("t3_nrd", count_reads(), 0);
    nack_wr_idx = -1;

    // 4: spurious done during write gaps
    spur = 1;
    restart();
    wait_done("t4_done");
    check_full_pass("t4");
    spur = 0;

    // 5: one-clock reset during third read
    restart();
    for (int i = 0; i < 1000 && count_reads() < 3; i++) tick();
    chk("t5_rd3", count_reads(), 3);
    rst_n = 0;
    tick();
    check_reset("t5_rst");
    log_q.delete();
    rst_n = 1;
    wait_done("t5_done");
    check_full_pass("t5");

    // 6: single byte, zero wait
    chk("t6_bit_ctrl_pre", b_bit_ctrl, 0);
    rst_n_b = 1;
    for (int i = 0; i < 200 && !b_rw_done; i++) tick();
    chk("t6_done", b_rw_done, 1);
    repeat (10) tick();
    chk("t6_result", b_rw_result, 1);
    chk("t6_err", b_err_addr, 0);
    chk("t6_nwr", b_wr, 1);
    chk("t6_nrd", b_rd, 1);
    chk("t6_bit_ctrl", b_bit_ctrl, 0);
    chk("bit_ctrl_a_end", bit_ctrl, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
